// File: rtl/exmem_master.sv
// Command-driven initiator for the MiniMIPS external memory port: READ, WRITE, COPY, FILL.
// Read data is captured RD_LAT cycles after the address cycle; every output is registered.
module exmem_master #(
  parameter int unsigned AW     = 8,
  parameter int unsigned DW     = 8,
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req,
  input  logic [1:0]    cmd,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] addr2,
  input  logic [7:0]    len,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_data,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_q
);

  localparam int unsigned CW = 8;
  localparam logic [1:0] CMD_READ  = 2'b00;
  localparam logic [1:0] CMD_WRITE = 2'b01;
  localparam logic [1:0] CMD_COPY  = 2'b10;
  localparam logic [1:0] CMD_FILL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR      = 3'd3,
    S_FILL    = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_cmd, w_cmd_nxt;
  logic [AW-1:0] r_addr2, w_addr2_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_busy, r_done, r_mem_wen;
  logic [DW-1:0] r_rdata, w_rdata_nxt;
  logic [AW-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DW-1:0] r_mem_data, w_mem_data_nxt;
  logic          w_mem_wen_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; r_cnt counts remaining wait cycles (RD_WAIT) or remaining writes (FILL)
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          case (cmd)
            CMD_READ, CMD_COPY: w_state_nxt = S_RD_ADDR;
            CMD_WRITE:          w_state_nxt = S_WR;
            default:            w_state_nxt = (len == 8'd0) ? S_DONE : S_FILL;
          endcase
        end
      end
      S_RD_ADDR: w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: if (r_cnt == '0) w_state_nxt = (r_cmd == CMD_COPY) ? S_WR : S_DONE;
      S_WR:      w_state_nxt = S_DONE;
      S_FILL:    if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the registered outputs and command context
  always_comb begin
    w_cmd_nxt      = r_cmd;
    w_addr2_nxt    = r_addr2;
    w_cnt_nxt      = r_cnt;
    w_rdata_nxt    = r_rdata;
    w_mem_addr_nxt = r_mem_addr;
    w_mem_data_nxt = r_mem_data;
    w_mem_wen_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_cmd_nxt      = cmd;
          w_addr2_nxt    = addr2;
          w_cnt_nxt      = len;
          w_mem_addr_nxt = addr;
          if (cmd == CMD_WRITE || (cmd == CMD_FILL && len != 8'd0)) begin
            w_mem_data_nxt = wdata;
            w_mem_wen_nxt  = 1'b1;
          end
        end
      end
      S_RD_ADDR: w_cnt_nxt = CW'(RD_LAT - 1);
      S_RD_WAIT: begin
        if (r_cnt == '0) begin
          w_rdata_nxt = mem_q;
          if (r_cmd == CMD_COPY) begin
            w_mem_addr_nxt = r_addr2;
            w_mem_data_nxt = mem_q;
            w_mem_wen_nxt  = 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_FILL: begin
        if (r_cnt != CW'(1)) begin
          w_mem_addr_nxt = r_mem_addr + AW'(1);
          w_mem_wen_nxt  = 1'b1;
          w_cnt_nxt      = r_cnt - CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and context registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= CMD_READ;
      r_addr2    <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rdata    <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_wen  <= 1'b0;
    end else begin
      r_cmd      <= w_cmd_nxt;
      r_addr2    <= w_addr2_nxt;
      r_cnt      <= w_cnt_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= (w_state_nxt == S_DONE);
      r_rdata    <= w_rdata_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_mem_data <= w_mem_data_nxt;
      r_mem_wen  <= w_mem_wen_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign mem_addr = r_mem_addr;
  assign mem_data = r_mem_data;
  assign mem_wen  = r_mem_wen;

endmodule
